// File: rtl/can_tx_scheduler.sv
// Two-requester arbiter and load/transmit sequencer in front of can_tx.
// Define CAN_SCHED_RR_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; capture ID/data and ack on the edge
// LOAD  | one-cycle Load_frame_datareg strobe, Frame_ready high
// XMIT  | T_frame held for FRAME_CYCLES cycles, tx_done in the last one
// GAP   | IFS_CYCLES idle cycles before the next capture is allowed
module can_tx_scheduler #(
    parameter int unsigned FRAME_CYCLES = 107,
    parameter int unsigned IFS_CYCLES   = 11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [10:0] req0_id,
    input  logic [63:0] req0_data,
    input  logic        req1_valid,
    input  logic [10:0] req1_id,
    input  logic [63:0] req1_data,
    output logic        req0_ack,
    output logic        req1_ack,
    output logic [11:0] Can_ID_Bus,
    output logic [63:0] can_tx_data_bus,
    output logic        Frame_ready,
    output logic        Load_frame_datareg,
    output logic        T_frame,
    output logic        busy,
    output logic        tx_done,
    output logic        tx_owner
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_XMIT,
        ST_GAP
    } state_t;

    localparam logic [15:0] FRAME_LOAD = 16'(FRAME_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD   = (IFS_CYCLES == 0) ? 16'd0 : 16'(IFS_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic        capture;
    logic        winner;

`ifdef CAN_SCHED_RR_EN
    logic        last_winner;

    // Resets to "requester 1 last" so requester 0 takes the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_winner <= 1'b1;
        end else if (capture) begin
            last_winner <= winner;
        end
    end
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        winner     = 1'b0;

`ifdef CAN_SCHED_RR_EN
        if (req0_valid && req1_valid) begin
            winner = ~last_winner;
        end else begin
            winner = req1_valid;
        end
`else
        winner = ~req0_valid & req1_valid;
`endif

        case (state)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    capture    = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_XMIT;
                cnt_next   = FRAME_LOAD;
            end
            ST_XMIT: begin
                if (cnt == 16'd0) begin
                    state_next = (IFS_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt == 16'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= 16'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Outputs are registered from the next-state decode so they line up with the state they describe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req0_ack           <= 1'b0;
            req1_ack           <= 1'b0;
            Load_frame_datareg <= 1'b0;
            Frame_ready        <= 1'b0;
            T_frame            <= 1'b0;
            tx_done            <= 1'b0;
            busy               <= 1'b0;
            tx_owner           <= 1'b0;
            Can_ID_Bus         <= 12'd0;
            can_tx_data_bus    <= 64'd0;
        end else begin
            req0_ack           <= capture & ~winner;
            req1_ack           <= capture & winner;
            Load_frame_datareg <= (state_next == ST_LOAD);
            Frame_ready        <= (state_next == ST_LOAD) || (state_next == ST_XMIT);
            T_frame            <= (state_next == ST_XMIT);
            tx_done            <= (state_next == ST_XMIT) && (cnt_next == 16'd0);
            busy               <= (state_next != ST_IDLE);
            if (capture) begin
                tx_owner        <= winner;
                Can_ID_Bus      <= {1'b0, (winner ? req1_id : req0_id)};
                can_tx_data_bus <= winner ? req1_data : req0_data;
            end
        end
    end

endmodule
